// File: rtl/capture_sequencer_if.sv
// Button inputs and register-load outputs of the capture sequencer.
// The slave side is the sequencer; the master side is whoever owns the pads and registers.
interface capture_sequencer_if;
    logic       btn_next;
    logic       btn_clr;
    logic       enA;
    logic       enB;
    logic       enO;
    logic       enS;
    logic [2:0] step;

    modport master (
        output btn_next,
        output btn_clr,
        input  enA,
        input  enB,
        input  enO,
        input  enS,
        input  step
    );

    modport slave (
        input  btn_next,
        input  btn_clr,
        output enA,
        output enB,
        output enO,
        output enS,
        output step
    );
endinterface

// File: rtl/capture_sequencer.sv
// Steps an operator through load A / load B / load opcode / store result from two raw
// push-buttons, each synchronised, debounced and edge-detected into single-cycle events.
module capture_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter bit          BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    capture_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_B    = 3'd1,
        S_OP   = 3'd2,
        S_EXEC = 3'd3,
        S_SHOW = 3'd4
    } state_t;

    localparam logic [23:0] CNT_LAST = 24'(DEBOUNCE_CYCLES - 1);
    localparam logic        RELEASED = BTN_ACTIVE_LOW;

    // Bit 0 carries the "next" button, bit 1 the "clear" button.
    logic [1:0]  w_raw;
    logic [1:0]  w_lvl;
    logic [1:0]  r_sync1;
    logic [1:0]  r_sync2;
    logic [1:0]  r_db;
    logic [1:0]  r_db_q;
    logic [1:0]  r_armed;
    logic [1:0]  r_evt;
    logic [1:0]  r_fill;
    logic [23:0] r_cnt [2];

    assign w_raw = {bus.btn_clr, bus.btn_next};
    assign w_lvl = BTN_ACTIVE_LOW ? ~r_sync2 : r_sync2;

    // A button only becomes armed once a genuine released sample is seen after reset, so a
    // button held through reset cannot produce an event until it is released and pressed again.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= {2{RELEASED}};
            r_sync2 <= {2{RELEASED}};
            r_db    <= '0;
            r_db_q  <= '0;
            r_armed <= '0;
            r_evt   <= '0;
            r_fill  <= '0;
            for (int b = 0; b < 2; b++) begin
                r_cnt[b] <= '0;
            end
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            r_db_q  <= r_db;
            r_evt   <= r_db & ~r_db_q & r_armed;
            if (r_fill != 2'd2) begin
                r_fill <= r_fill + 2'd1;
            end
            for (int b = 0; b < 2; b++) begin
                if (r_fill == 2'd2 && !w_lvl[b]) begin
                    r_armed[b] <= 1'b1;
                end
                if (w_lvl[b] == r_db[b]) begin
                    r_cnt[b] <= '0;
                end else if (r_cnt[b] == CNT_LAST) begin
                    r_cnt[b] <= '0;
                    r_db[b]  <= w_lvl[b];
                end else begin
                    r_cnt[b] <= r_cnt[b] + 24'd1;
                end
            end
        end
    end

    logic       w_next_evt;
    logic       w_clr_evt;
    logic [2:0] r_state;
    state_t     w_state_nxt;
    logic [3:0] r_en;
    logic [3:0] w_en_nxt;

    assign w_next_evt = r_evt[0];
    assign w_clr_evt  = r_evt[1];

    // Enables are ordered {enA, enB, enO, enS}; clear overrides any simultaneous next event.
    always_comb begin
        w_state_nxt = S_A;
        w_en_nxt    = 4'b0000;
        if (!w_clr_evt) begin
            case (r_state)
                S_A: begin
                    w_state_nxt = w_next_evt ? S_B : S_A;
                    w_en_nxt    = w_next_evt ? 4'b1000 : 4'b0000;
                end
                S_B: begin
                    w_state_nxt = w_next_evt ? S_OP : S_B;
                    w_en_nxt    = w_next_evt ? 4'b0100 : 4'b0000;
                end
                S_OP: begin
                    w_state_nxt = w_next_evt ? S_EXEC : S_OP;
                    w_en_nxt    = w_next_evt ? 4'b0010 : 4'b0000;
                end
                S_EXEC: begin
                    w_state_nxt = S_SHOW;
                    w_en_nxt    = 4'b0001;
                end
                S_SHOW: begin
                    w_state_nxt = w_next_evt ? S_A : S_SHOW;
                end
                default: begin
                    w_state_nxt = S_A;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_A;
            r_en    <= 4'b0000;
        end else begin
            r_state <= w_state_nxt;
            r_en    <= w_en_nxt;
        end
    end

    assign bus.enA  = r_en[3];
    assign bus.enB  = r_en[2];
    assign bus.enO  = r_en[1];
    assign bus.enS  = r_en[0];
    assign bus.step = r_state;

endmodule

// File: tb/tb_capture_sequencer.sv
// Bench for capture_sequencer: table-driven press scenarios, hand-written corner cases and a
// randomised run against a sample-window reference model.
module tb_capture_sequencer;

    localparam int D = 4;

    logic clk;
    logic rst;

    capture_sequencer_if u_if ();

    capture_sequencer #(
        .DEBOUNCE_CYCLES(D),
        .BTN_ACTIVE_LOW (1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(u_if.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp;
    int n_bad;

    typedef struct {
        bit         nxt;
        bit         clr;
        int         hold;
        logic [3:0] en7;
        logic [3:0] en8;
        int         npulse;
        logic [2:0] step;
    } vec_t;

    vec_t vecs [8];

    function automatic logic [3:0] en_now();
        return {u_if.enA, u_if.enB, u_if.enO, u_if.enS};
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Press the selected buttons from edge t0 for v.hold samples, then release and observe.
    task automatic run_press(input vec_t v, input string tag);
        logic [3:0] cur;
        logic [3:0] en7;
        logic [3:0] en8;
        int         np;
        en7 = 4'b0000;
        en8 = 4'b0000;
        np  = 0;
        @(negedge clk);
        u_if.btn_next = v.nxt ? 1'b0 : 1'b1;
        u_if.btn_clr  = v.clr ? 1'b0 : 1'b1;
        for (int k = 0; k < v.hold + 14; k++) begin
            @(posedge clk);
            #1;
            cur = en_now();
            if (k == 7) en7 = cur;
            if (k == 8) en8 = cur;
            if (cur != 4'b0000) np++;
            if (k == v.hold - 1) begin
                u_if.btn_next = 1'b1;
                u_if.btn_clr  = 1'b1;
            end
        end
        check({tag, "_en_t7"}, 8'(en7), 8'(v.en7));
        check({tag, "_en_t8"}, 8'(en8), 8'(v.en8));
        check({tag, "_pulses"}, 8'(np), 8'(v.npulse));
        check({tag, "_step"}, 8'(u_if.step), 8'(v.step));
    endtask

    // Reference model: a debounced level flips when the D pad samples taken 2..D+1 edges ago
    // all disagree with it; rises become events two edges later if a genuine released sample
    // has been seen since reset.
    bit         m_hist  [2][D+1];
    bit         m_db    [2];
    bit         m_armed [2];
    bit         m_rise1 [2];
    bit         m_rise2 [2];
    int         m_real;
    int         m_state;
    logic [3:0] m_en;

    task automatic model_reset();
        for (int b = 0; b < 2; b++) begin
            for (int k = 0; k <= D; k++) m_hist[b][k] = 1'b0;
            m_db[b]    = 1'b0;
            m_armed[b] = 1'b0;
            m_rise1[b] = 1'b0;
            m_rise2[b] = 1'b0;
        end
        m_real  = 0;
        m_state = 0;
        m_en    = 4'b0000;
    endtask

    task automatic model_edge(input bit pn, input bit pc);
        bit p   [2];
        bit evt [2];
        bit flip;
        p[0] = pn;
        p[1] = pc;
        for (int b = 0; b < 2; b++) begin
            if (m_real >= 2 && !m_hist[b][1]) m_armed[b] = 1'b1;
            evt[b]     = m_rise2[b];
            m_rise2[b] = m_rise1[b];
            m_rise1[b] = 1'b0;
            flip = 1'b1;
            for (int k = 1; k <= D; k++) begin
                if (m_hist[b][k] == m_db[b]) flip = 1'b0;
            end
            if (flip) begin
                m_db[b]    = !m_db[b];
                m_rise1[b] = m_db[b] && m_armed[b];
            end
            for (int k = D; k > 0; k--) m_hist[b][k] = m_hist[b][k-1];
            m_hist[b][0] = p[b];
        end
        if (m_real < 2) m_real++;
        m_en = 4'b0000;
        if (evt[1]) begin
            m_state = 0;
        end else if (m_state == 3) begin
            m_en    = 4'b0001;
            m_state = 4;
        end else if (m_state > 4) begin
            m_state = 0;
        end else if (evt[0]) begin
            if (m_state < 3) m_en = 4'b1000 >> m_state;
            m_state = (m_state == 4) ? 0 : m_state + 1;
        end
    endtask

    initial begin
        vec_t v;
        int   np;
        int   en19;
        int   onehot_bad;
        int   rem_n;
        int   rem_c;
        bit   pn;
        bit   pc;

        n_cmp = 0;
        n_bad = 0;
        onehot_bad = 0;

        vecs[0] = '{1'b1, 1'b0, 20, 4'b1000, 4'b0000, 1, 3'd1};
        vecs[1] = '{1'b1, 1'b0,  5, 4'b0100, 4'b0000, 1, 3'd2};
        vecs[2] = '{1'b1, 1'b0,  5, 4'b0010, 4'b0001, 2, 3'd4};
        vecs[3] = '{1'b1, 1'b0,  5, 4'b0000, 4'b0000, 0, 3'd0};
        vecs[4] = '{1'b1, 1'b0,  5, 4'b1000, 4'b0000, 1, 3'd1};
        vecs[5] = '{1'b1, 1'b1,  5, 4'b0000, 4'b0000, 0, 3'd0};
        vecs[6] = '{1'b1, 1'b0,  6, 4'b1000, 4'b0000, 1, 3'd1};
        vecs[7] = '{1'b0, 1'b1,  5, 4'b0000, 4'b0000, 0, 3'd0};

        rst = 1'b1;
        u_if.btn_next = 1'b1;
        u_if.btn_clr  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_step", 8'(u_if.step), 8'd0);
        check("reset_en", 8'(en_now()), 8'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(posedge clk);

        for (int i = 0; i < 8; i++) begin
            run_press(vecs[i], $sformatf("vec%0d", i));
        end

        // Bounce: 3-cycle glitches pressed/released, then a stable press from edge 12.
        np   = 0;
        en19 = 0;
        for (int j = 0; j < 40; j++) begin
            if (j < 12) u_if.btn_next = ((j / 3) % 2 == 0) ? 1'b0 : 1'b1;
            else        u_if.btn_next = (j < 26) ? 1'b0 : 1'b1;
            @(posedge clk);
            #1;
            if (en_now() != 4'b0000) np++;
            if (j == 19) en19 = int'(en_now());
        end
        check("bounce_en_t7", 8'(en19), 8'b1000);
        check("bounce_pulses", 8'(np), 8'd1);
        check("bounce_step", 8'(u_if.step), 8'd1);

        // Reset while in S_OP with next held mid-debounce.
        v = '{1'b1, 1'b0, 5, 4'b0100, 4'b0000, 1, 3'd2};
        run_press(v, "to_op");
        np = 0;
        @(negedge clk);
        u_if.btn_next = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            #1;
            if (en_now() != 4'b0000) np++;
            if (k == 2) rst = 1'b1;
            if (k == 3) begin
                rst = 1'b0;
                check("rst_step_now", 8'(u_if.step), 8'd0);
            end
        end
        check("rst_held_step", 8'(u_if.step), 8'd0);
        u_if.btn_next = 1'b1;
        for (int k = 0; k < 14; k++) begin
            @(posedge clk);
            #1;
            if (en_now() != 4'b0000) np++;
        end
        check("rst_held_pulses", 8'(np), 8'd0);
        v = '{1'b1, 1'b0, 5, 4'b1000, 4'b0000, 1, 3'd1};
        run_press(v, "after_rst");

        // Unused state code recovers to S_A without a pulse.
        @(negedge clk);
        force dut.r_state = 3'd6;
        #1;
        release dut.r_state;
        @(posedge clk);
        #1;
        check("bad_state_step", 8'(u_if.step), 8'd0);
        check("bad_state_en", 8'(en_now()), 8'd0);

        // Randomised run against the reference model.
        @(negedge clk);
        rst = 1'b1;
        u_if.btn_next = 1'b1;
        u_if.btn_clr  = 1'b1;
        @(posedge clk);
        model_reset();
        @(negedge clk);
        rst   = 1'b0;
        rem_n = 0;
        rem_c = 0;
        pn    = 1'b0;
        pc    = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (rem_n == 0) begin
                pn    = 1'($urandom_range(0, 1));
                rem_n = $urandom_range(1, 8);
            end
            if (rem_c == 0) begin
                pc    = ($urandom_range(0, 5) == 0);
                rem_c = $urandom_range(1, 8);
            end
            rem_n--;
            rem_c--;
            u_if.btn_next = !pn;
            u_if.btn_clr  = !pc;
            @(posedge clk);
            model_edge(pn, pc);
            #1;
            check($sformatf("rand%0d_step", i), 8'(u_if.step), 8'(m_state));
            check($sformatf("rand%0d_en", i), 8'(en_now()), 8'(m_en));
            if ($countones(en_now()) > 1) onehot_bad++;
            @(negedge clk);
        end
        check("onehot_violations", 8'(onehot_bad), 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
